// File: rtl/demod_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// demod_reg_bus_arbiter
//   Shares one asynchronous-strobe register bus between the host port
//   (reads and writes) and the auto-acquisition engine (writes only).
//   Every access runs IDLE -> SETUP (1) -> STROBE (STROBE_CYCLES) -> HOLD (1)
//   and is acknowledged with a one-cycle pulse in the IDLE cycle that follows,
//   giving a request-to-ack latency of STROBE_CYCLES+3 cycles.
//
//   Build option: DEMOD_ARB_ROUND_ROBIN_EN
//     undefined : host has fixed priority when both ports request.
//     defined   : contention is resolved round-robin (host first after reset).
//
// Ports
//   clk, nReset                         clock, async active-low reset
//   hostReq/Write/Addr/Data/Be          host access request
//   hostAck, hostRdData                 host completion pulse, last read value
//   autoReq/Addr/Data/Be, autoAck       engine write request and completion
//   busAddr, busData, busCs             shared register bus
//   busWr[3:0]                          active-low byte strobes (data[8n+7:8n])
//   busRdData                           register-file read data
//   busy                                high whenever an access is in flight
// -----------------------------------------------------------------------------
module demod_reg_bus_arbiter #(
  parameter int STROBE_CYCLES = 2   // strobe low time in clk cycles, 1..15
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        hostReq,
  input  logic        hostWrite,
  input  logic [11:0] hostAddr,
  input  logic [31:0] hostData,
  input  logic [3:0]  hostBe,
  output logic        hostAck,
  output logic [31:0] hostRdData,
  input  logic        autoReq,
  input  logic [11:0] autoAddr,
  input  logic [31:0] autoData,
  input  logic [3:0]  autoBe,
  output logic        autoAck,
  output logic [11:0] busAddr,
  output logic [31:0] busData,
  output logic        busCs,
  output logic [3:0]  busWr,
  input  logic [31:0] busRdData,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state;
  logic [3:0] strbCnt;
  logic [3:0] beReg;
  logic       wrReg;
  logic       ownerHost;
  logic       grantHost;
  logic       grantAuto;
  logic       arbEn;

`ifdef DEMOD_ARB_ROUND_ROBIN_EN
  logic       hostFirst;  // priority pointer: 1 = host wins the next tie
`endif

  // The cycle carrying an ack is never a grant cycle. The acked requester still
  // shows its old request there, so it is ineligible; holding off the other
  // port too lets a requester that immediately re-requests compete on equal
  // terms in the next cycle (otherwise fixed priority would degrade to
  // alternation whenever both ports are held busy).
  assign arbEn = (state == IDLE) && !hostAck && !autoAck;

  always_comb begin
    grantHost = 1'b0;
    grantAuto = 1'b0;
    if (arbEn) begin
`ifdef DEMOD_ARB_ROUND_ROBIN_EN
      if (hostReq && autoReq) begin
        grantHost = hostFirst;
        grantAuto = !hostFirst;
      end else begin
        grantHost = hostReq;
        grantAuto = autoReq;
      end
`else
      grantHost = hostReq;
      grantAuto = autoReq && !hostReq;
`endif
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      strbCnt    <= '0;
      beReg      <= '0;
      wrReg      <= 1'b0;
      ownerHost  <= 1'b0;
      busAddr    <= '0;
      busData    <= '0;
      busCs      <= 1'b0;
      busWr      <= 4'hF;
      busy       <= 1'b0;
      hostAck    <= 1'b0;
      autoAck    <= 1'b0;
      hostRdData <= '0;
`ifdef DEMOD_ARB_ROUND_ROBIN_EN
      hostFirst  <= 1'b1;
`endif
    end else begin
      hostAck <= 1'b0;
      autoAck <= 1'b0;
      case (state)
        IDLE: begin
          if (grantHost || grantAuto) begin
            busAddr   <= grantHost ? hostAddr : autoAddr;
            busData   <= grantHost ? hostData : autoData;
            beReg     <= grantHost ? hostBe   : autoBe;
            wrReg     <= grantHost ? hostWrite : 1'b1;  // engine only writes
            ownerHost <= grantHost;
            busCs     <= 1'b1;
            busy      <= 1'b1;
            state     <= SETUP;
`ifdef DEMOD_ARB_ROUND_ROBIN_EN
            hostFirst <= !grantHost;
`endif
          end
        end
        SETUP: begin
          // Reads and be=0 writes still walk the strobe phase, just with
          // every strobe held high.
          busWr   <= ~(beReg & {4{wrReg}});
          strbCnt <= 4'(STROBE_CYCLES - 1);
          state   <= STROBE;
        end
        STROBE: begin
          if (strbCnt == 4'd0) begin
            busWr <= 4'hF;
            state <= HOLD;
          end else begin
            strbCnt <= strbCnt - 4'd1;
          end
        end
        HOLD: begin
          busCs <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (ownerHost) begin
            hostAck <= 1'b1;
            if (!wrReg) hostRdData <= busRdData;
          end else begin
            autoAck <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_demod_reg_bus_arbiter
//   Scoreboarded bench: drivers push each issued access into a per-port queue,
//   a negedge monitor pops on every ack and checks it against a reference
//   register image updated in ack order. A simple register file model answers
//   the bus and captures bytes on the falling edge of each strobe.
// -----------------------------------------------------------------------------
module tb_demod_reg_bus_arbiter;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        nReset;
  logic        hostReq, hostWrite, autoReq;
  logic [11:0] hostAddr, autoAddr;
  logic [31:0] hostData, autoData;
  logic [3:0]  hostBe, autoBe;
  logic        hostAck, autoAck, busCs, busy;
  logic [31:0] hostRdData, busData, busRdData;
  logic [11:0] busAddr;
  logic [3:0]  busWr;

  demod_reg_bus_arbiter #(.STROBE_CYCLES(S)) dut (
    .clk(clk), .nReset(nReset),
    .hostReq(hostReq), .hostWrite(hostWrite), .hostAddr(hostAddr),
    .hostData(hostData), .hostBe(hostBe), .hostAck(hostAck),
    .hostRdData(hostRdData),
    .autoReq(autoReq), .autoAddr(autoAddr), .autoData(autoData),
    .autoBe(autoBe), .autoAck(autoAck),
    .busAddr(busAddr), .busData(busData), .busCs(busCs), .busWr(busWr),
    .busRdData(busRdData), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          issue;
    int          expLat;   // 0 = latency not checked
  } txn_t;

  txn_t        hostQ[$];
  txn_t        autoQ[$];
  bit          ackWho[$];        // 1 = host, in ack order
  logic [31:0] refMem[int];      // reference image, only written entries
  logic [31:0] rf[0:4095];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lowCycles = 0;    // cycles with any strobe low
  logic [3:0]  lastStrobe = 4'hF;
  int          lowRun[4] = '{default: 0};

  function automatic logic [31:0] initVal(input int a);
    if (a == 24) return 32'h0000_000B;
    return (a * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] refVal(input int a);
    if (refMem.exists(a)) return refMem[a];
    return initVal(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Register file: combinational read, byte capture on each strobe falling edge.
  assign busRdData = rf[busAddr];
  initial begin
    logic [3:0] prevWr;
    for (int i = 0; i < 4096; i++) rf[i] = initVal(i);
    prevWr = 4'hF;
    forever begin
      @(busWr);
      for (int n = 0; n < 4; n++)
        if (prevWr[n] && !busWr[n] && busCs) rf[busAddr][8*n +: 8] = busData[8*n +: 8];
      prevWr = busWr;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    txn_t e;
    if (nReset) begin
      if (hostAck || autoAck) chk("ackExclusive", {31'd0, hostAck & autoAck}, 32'd0);
      if (hostAck) begin
        ackWho.push_back(1'b1);
        if (hostQ.size() == 0) chk("hostAckUnexpected", 32'd1, 32'd0);
        else begin
          e = hostQ.pop_front();
          if (e.wr) begin
            logic [31:0] v;
            v = refVal(int'(e.addr));
            for (int n = 0; n < 4; n++) if (e.be[n]) v[8*n +: 8] = e.data[8*n +: 8];
            refMem[int'(e.addr)] = v;
          end else chk("hostRdData", hostRdData, refVal(int'(e.addr)));
          if (e.expLat != 0) chk("hostLatency", cyc - e.issue, e.expLat);
        end
      end
      if (autoAck) begin
        ackWho.push_back(1'b0);
        if (autoQ.size() == 0) chk("autoAckUnexpected", 32'd1, 32'd0);
        else begin
          logic [31:0] v;
          e = autoQ.pop_front();
          v = refVal(int'(e.addr));
          for (int n = 0; n < 4; n++) if (e.be[n]) v[8*n +: 8] = e.data[8*n +: 8];
          refMem[int'(e.addr)] = v;
          if (e.expLat != 0) chk("autoLatency", cyc - e.issue, e.expLat);
        end
      end
      chk("busyVsCs", {31'd0, busy}, {31'd0, busCs});
      if (busWr != 4'hF) begin
        lowCycles++;
        lastStrobe = busWr;
        chk("strobeNeedsCs", {31'd0, busCs}, 32'd1);
      end
      for (int n = 0; n < 4; n++) begin
        if (!busWr[n]) lowRun[n]++;
        else if (lowRun[n] != 0) begin
          chk("strobeWidth", lowRun[n], S);
          lowRun[n] = 0;
        end
      end
    end else begin
      for (int n = 0; n < 4; n++) lowRun[n] = 0;
    end
  end

  task automatic waitAck(input bit host, output int ackCyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(host ? hostAck : autoAck) && n < 200);
    if (!(host ? hostAck : autoAck)) chk(host ? "hostAckTimeout" : "autoAckTimeout", 32'd0, 32'd1);
    ackCyc = cyc;
  endtask

  // Called on a negedge; returns on the negedge where the ack is seen.
  task automatic hostAccess(input bit wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] be, input int expLat, input bit keep,
                            output int ackCyc);
    txn_t e;
    e.wr = wr; e.addr = a; e.data = d; e.be = be; e.issue = cyc; e.expLat = expLat;
    hostQ.push_back(e);
    hostWrite = wr; hostAddr = a; hostData = d; hostBe = be; hostReq = 1'b1;
    waitAck(1'b1, ackCyc);
    if (!keep) hostReq = 1'b0;
  endtask

  task automatic autoAccess(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                            input int expLat, input bit keep, output int ackCyc);
    txn_t e;
    e.wr = 1'b1; e.addr = a; e.data = d; e.be = be; e.issue = cyc; e.expLat = expLat;
    autoQ.push_back(e);
    autoAddr = a; autoData = d; autoBe = be; autoReq = 1'b1;
    waitAck(1'b0, ackCyc);
    if (!keep) autoReq = 1'b0;
  endtask

  initial begin
    int ac, ac2, rel, base, lc;
    nReset = 1'b0;
    hostReq = 0; hostWrite = 0; hostAddr = '0; hostData = '0; hostBe = '0;
    autoReq = 0; autoAddr = '0; autoData = '0; autoBe = '0;

    // Reset state
    #12;
    chk("rstBusWr", {28'd0, busWr}, 32'hF);
    chk("rstBusCs", {31'd0, busCs}, 32'd0);
    chk("rstBusAddr", {20'd0, busAddr}, 32'd0);
    chk("rstBusData", busData, 32'd0);
    chk("rstHostAck", {31'd0, hostAck}, 32'd0);
    chk("rstAutoAck", {31'd0, autoAck}, 32'd0);
    chk("rstHostRdData", hostRdData, 32'd0);
    chk("rstBusy", {31'd0, busy}, 32'd0);
    @(negedge clk); nReset = 1'b1;
    repeat (2) @(negedge clk);

    // Host write with partial byte enables, then read it back
    hostAccess(1'b1, 12'h010, 32'h0003_0005, 4'h5, S + 3, 1'b0, ac);
    chk("wrStrobePattern", {28'd0, lastStrobe}, 32'hA);
    @(negedge clk);
    hostAccess(1'b0, 12'h010, 32'h0, 4'hF, S + 3, 1'b0, ac);
    chk("wrMergedReadback", hostRdData, (initVal(16) & 32'hFF00_FF00) | 32'h0003_0005);

    // Host read: no strobe at all
    @(negedge clk);
    lc = lowCycles;
    hostAccess(1'b0, 12'h018, 32'h0, 4'hF, S + 3, 1'b0, ac);
    chk("readNoStrobe", lowCycles - lc, 32'd0);
    chk("readValue", hostRdData, 32'h0000_000B);

    // Auto write with be=0: full sequence, no strobe, ack, hostRdData untouched
    @(negedge clk);
    lc = lowCycles;
    autoAccess(12'h020, 32'hDEAD_BEEF, 4'h0, S + 3, 1'b0, ac);
    chk("beZeroNoStrobe", lowCycles - lc, 32'd0);
    chk("hostRdDataHeld", hostRdData, 32'h0000_000B);

    // Contention: host issues three back-to-back, auto one, both start together
    repeat (2) @(negedge clk);
    base = ackWho.size();
    fork
      begin
        hostAccess(1'b1, 12'h040, 32'h1111_1111, 4'hF, 0, 1'b1, ac);
        hostAccess(1'b1, 12'h041, 32'h2222_2222, 4'hF, 0, 1'b1, ac);
        hostAccess(1'b1, 12'h042, 32'h3333_3333, 4'hF, 0, 1'b0, ac);
      end
      autoAccess(12'h043, 32'h4444_4444, 4'hF, 0, 1'b0, ac2);
    join
    @(negedge clk);
    chk("arbAckCount", ackWho.size() - base, 32'd4);
    if (ackWho.size() - base == 4) begin
`ifdef DEMOD_ARB_ROUND_ROBIN_EN
      chk("arbOrder", {28'd0, ackWho[base], ackWho[base+1], ackWho[base+2], ackWho[base+3]}, 32'b1011);
`else
      chk("arbOrder", {28'd0, ackWho[base], ackWho[base+1], ackWho[base+2], ackWho[base+3]}, 32'b1110);
`endif
    end

    // Reset during STROBE of an auto write; held request re-served in full
    repeat (2) @(negedge clk);
    rel = 0;
    fork
      autoAccess(12'h030, 32'hCAFE_F00D, 4'hF, 0, 1'b0, ac);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (busWr == 4'hF && n < 50);
        chk("sawStrobeBeforeReset", {28'd0, busWr}, 32'h0);
        nReset = 1'b0;
        #1;
        chk("abortBusWr", {28'd0, busWr}, 32'hF);
        chk("abortBusCs", {31'd0, busCs}, 32'd0);
        chk("abortBusy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("abortNoAck", {31'd0, autoAck}, 32'd0);
        nReset = 1'b1;
        rel = cyc;
      end
    join
    chk("reServeLatency", ac - rel, S + 3);

    // Randomized concurrent traffic
    @(negedge clk);
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        hostAccess(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom,
                   4'($urandom_range(0, 15)), 0, 1'b0, ac);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        autoAccess(12'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 0, 1'b0, ac2);
      end
    join
    // Read back every randomly written location
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      hostAccess(1'b0, 12'(a), 32'h0, 4'hF, S + 3, 1'b0, ac);
    end

    repeat (4) @(negedge clk);
    chk("hostQEmpty", hostQ.size(), 32'd0);
    chk("autoQEmpty", autoQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
